// File: rtl/obi_rvalid_delay_pkg.sv
// Shared definitions for the OBI perturbation stages: stall-mode codes,
// LFSR polynomial, response buffer entry layout and the LFSR step function.
package perturbation_defines;

  localparam logic [31:0] STANDARD  = 32'd0;
  localparam logic [31:0] RANDOM    = 32'd1;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Entry data field width; the response stage zero-extends/truncates into it.
  localparam int unsigned ENTRY_DATA_W = 32;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] data;
    logic                    err;
    logic [31:0]             delay;
  } rvalid_entry_t;

  // One step of a right-shifting Galois LFSR with tap mask poly.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] poly);
    logic [31:0] shifted;
    shifted = {1'b0, state[31:1]};
    if (state[0]) begin
      return shifted ^ poly;
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/obi_delay_lfsr.sv
// Seedable 32-bit Galois LFSR that steps once per advance strobe.
// Shared by the grant and response perturbation stages as a synthesizable
// pseudo-random source.
module obi_delay_lfsr
  import perturbation_defines::*;
#(
  parameter logic [31:0] SEED = 32'h1,
  parameter logic [31:0] POLY = LFSR_POLY
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        advance_i,
  output logic [31:0] state_o
);

  logic [31:0] state_r;

  // LFSR state register: reload seed on reset, step on advance.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= SEED;
    end else if (advance_i) begin
      state_r <= lfsr_next(state_r, POLY);
    end
  end

  assign state_o = state_r;

endmodule

// File: rtl/obi_rvalid_delay.sv
// Response-phase perturbation stage. Buffers memory responses in order and
// releases each one to the core after a per-entry stall chosen at push time.
// Also counts granted-but-unanswered transactions so the grant stage can hold
// off when the buffer could not absorb another response.
module obi_rvalid_delay
  import perturbation_defines::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] LFSR_SEED  = 32'h1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_i,
  input  logic                              gnt_i,
  input  logic                              mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i,
  input  logic                              mem_err_i,
  output logic                              rvalid_core_o,
  output logic [DATA_WIDTH-1:0]             rdata_core_o,
  output logic                              err_core_o,
  input  logic                              en_stall_i,
  input  logic [31:0]                       stall_mode_i,
  input  logic [31:0]                       max_stall_i,
  input  logic [31:0]                       rvalid_stall_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   outstanding_o,
  output logic                              gnt_block_o,
  output logic                              overflow_o,
  output logic                              protocol_err_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

  rvalid_entry_t    mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [PTR_W-1:0] rptr_inc_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] outstanding_r;
  logic [CNT_W-1:0] outstanding_nxt_s;
  logic [31:0]      head_cnt_r;
  logic [31:0]      head_cnt_nxt_s;
  logic [31:0]      lfsr_s;
  logic [31:0]      delay_s;
  logic             overflow_r;
  logic             overflow_nxt_s;
  logic             protocol_err_r;
  logic             protocol_err_nxt_s;
  logic             empty_s;
  logic             full_s;
  logic             rvalid_s;
  logic             pop_s;
  logic             push_s;
  logic             grant_s;
  rvalid_entry_t    push_entry_s;
  rvalid_entry_t    head_entry_s;
  rvalid_entry_t    next_entry_s;

  assign empty_s    = (count_r == '0);
  assign full_s     = (count_r == DEPTH_C);
  assign rvalid_s   = !empty_s && (head_cnt_r == 32'd0);
  assign pop_s      = rvalid_s;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push_s     = mem_rvalid_i && (!full_s || pop_s);
  assign grant_s    = req_i && gnt_i;
  assign rptr_inc_s = rptr_r + PTR_ONE;

  assign head_entry_s = mem_r[rptr_r];
  assign next_entry_s = mem_r[rptr_inc_s];

  obi_delay_lfsr #(
    .SEED (LFSR_SEED),
    .POLY (LFSR_POLY)
  ) u_lfsr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .advance_i (push_s),
    .state_o   (lfsr_s)
  );

  // Delay for the entry being pushed this cycle, chosen from the stall mode.
  always_comb begin
    delay_s = 32'd0;
    if (!en_stall_i) begin
      delay_s = 32'd0;
    end else begin
      case (stall_mode_i)
        STANDARD: delay_s = rvalid_stall_i;
        RANDOM: begin
          // max+1 would wrap to zero for the all-ones bound, so use lfsr as-is.
          if (max_stall_i == 32'hFFFF_FFFF) begin
            delay_s = lfsr_s;
          end else begin
            delay_s = lfsr_s % (max_stall_i + 32'd1);
          end
        end
        default: delay_s = 32'd0;
      endcase
    end
  end

  // Entry being written: data, error flag and its release delay.
  always_comb begin
    push_entry_s       = '0;
    push_entry_s.data  = ENTRY_DATA_W'(mem_rdata_i);
    push_entry_s.err   = mem_err_i;
    push_entry_s.delay = delay_s;
  end

  // Next value of the buffer occupancy.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Head countdown: load on a new head, otherwise count down to zero.
  always_comb begin
    head_cnt_nxt_s = head_cnt_r;
    if (push_s && (empty_s || (pop_s && (count_r == ONE_C)))) begin
      head_cnt_nxt_s = delay_s;
    end else if (pop_s && (count_r != ONE_C)) begin
      head_cnt_nxt_s = next_entry_s.delay;
    end else if (head_cnt_r != 32'd0) begin
      head_cnt_nxt_s = head_cnt_r - 32'd1;
    end else begin
      head_cnt_nxt_s = head_cnt_r;
    end
  end

  // Outstanding counter and protocol error: a response with nothing
  // outstanding leaves the counter at zero and raises the sticky flag.
  always_comb begin
    outstanding_nxt_s  = outstanding_r;
    protocol_err_nxt_s = protocol_err_r;
    case ({grant_s, pop_s})
      2'b10: begin
        if (outstanding_r != DEPTH_C) begin
          outstanding_nxt_s = outstanding_r + ONE_C;
        end else begin
          outstanding_nxt_s = outstanding_r;
        end
      end
      2'b01: begin
        if (outstanding_r == '0) begin
          protocol_err_nxt_s = 1'b1;
        end else begin
          outstanding_nxt_s = outstanding_r - ONE_C;
        end
      end
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // Overflow: a response arriving at a full buffer with no pop is dropped.
  always_comb begin
    if (mem_rvalid_i && full_s && !pop_s) begin
      overflow_nxt_s = 1'b1;
    end else begin
      overflow_nxt_s = overflow_r;
    end
  end

  // Entry storage; contents are only ever read behind the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wptr_r] <= push_entry_s;
    end
  end

  // Control state: pointers, occupancy, countdown, outstanding and flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_r         <= '0;
      rptr_r         <= '0;
      count_r        <= '0;
      head_cnt_r     <= 32'd0;
      outstanding_r  <= '0;
      overflow_r     <= 1'b0;
      protocol_err_r <= 1'b0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rptr_r <= rptr_inc_s;
      end
      count_r        <= count_nxt_s;
      head_cnt_r     <= head_cnt_nxt_s;
      outstanding_r  <= outstanding_nxt_s;
      overflow_r     <= overflow_nxt_s;
      protocol_err_r <= protocol_err_nxt_s;
    end
  end

  assign rvalid_core_o  = rvalid_s;
  assign rdata_core_o   = rvalid_s ? DATA_WIDTH'(head_entry_s.data) : '0;
  assign err_core_o     = rvalid_s ? head_entry_s.err : 1'b0;
  assign outstanding_o  = outstanding_r;
  assign gnt_block_o    = (outstanding_r >= DEPTH_C);
  assign overflow_o     = overflow_r;
  assign protocol_err_o = protocol_err_r;

endmodule

// File: tb/tb_obi_rvalid_delay.sv
// Self-checking bench for obi_rvalid_delay. A transaction-level model
// predicts each response's release cycle as max(push, predecessor release)+1+d.
module tb_obi_rvalid_delay;
  import perturbation_defines::*;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni, req_i, gnt_i, mem_rvalid_i, mem_err_i, en_stall_i;
  logic [31:0] mem_rdata_i, stall_mode_i, max_stall_i, rvalid_stall_i;
  logic        rvalid_core_o, err_core_o, gnt_block_o, overflow_o, protocol_err_o;
  logic [31:0] rdata_core_o;
  logic [2:0]  outstanding_o;

  obi_rvalid_delay #(
    .FIFO_DEPTH (DEPTH),
    .DATA_WIDTH (32),
    .LFSR_SEED  (32'h1)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .gnt_i          (gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i),
    .rvalid_core_o  (rvalid_core_o),
    .rdata_core_o   (rdata_core_o),
    .err_core_o     (err_core_o),
    .en_stall_i     (en_stall_i),
    .stall_mode_i   (stall_mode_i),
    .max_stall_i    (max_stall_i),
    .rvalid_stall_i (rvalid_stall_i),
    .outstanding_o  (outstanding_o),
    .gnt_block_o    (gnt_block_o),
    .overflow_o     (overflow_o),
    .protocol_err_o (protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic        err;
    longint      out_cyc;
  } exp_t;

  exp_t        mq[$];
  longint      last_out = -1000;
  logic [31:0] m_lfsr = 32'h1;
  int          m_out = 0;
  logic        m_ovf = 1'b0, m_perr = 1'b0;

  logic        e_rv, e_err, e_blk;
  logic [31:0] e_data;
  logic [2:0]  e_out;

  function automatic logic [31:0] m_delay();
    if (!en_stall_i) return 32'd0;
    if (stall_mode_i == STANDARD) return rvalid_stall_i;
    if (stall_mode_i == RANDOM) begin
      if (max_stall_i == 32'hFFFF_FFFF) return m_lfsr;
      return 32'(longint'(m_lfsr) % (longint'(max_stall_i) + 64'sd1));
    end
    return 32'd0;
  endfunction

  task automatic model_expect();
    e_rv   = (mq.size() > 0) && (mq[0].out_cyc == cyc);
    e_data = e_rv ? mq[0].data : 32'd0;
    e_err  = e_rv ? mq[0].err : 1'b0;
    e_out  = 3'(m_out);
    e_blk  = (m_out >= DEPTH);
  endtask

  task automatic model_update();
    bit          pop;
    int          occ;
    longint      h;
    logic [31:0] d;
    exp_t        e;
    if (!rst_ni) begin
      mq.delete();
      last_out = -1000;
      m_lfsr   = 32'h1;
      m_out    = 0;
      m_ovf    = 1'b0;
      m_perr   = 1'b0;
      return;
    end
    pop = (mq.size() > 0) && (mq[0].out_cyc == cyc);
    occ = mq.size();
    if (pop) void'(mq.pop_front());
    if (mem_rvalid_i) begin
      if (occ == DEPTH && !pop) begin
        m_ovf = 1'b1;
      end else begin
        d = m_delay();
        h = (cyc > last_out) ? cyc : last_out;
        e.data = mem_rdata_i;
        e.err = mem_err_i;
        e.out_cyc = h + 1 + longint'(d);
        mq.push_back(e);
        last_out = e.out_cyc;
        m_lfsr = m_lfsr[0] ? ({1'b0, m_lfsr[31:1]} ^ 32'h8020_0003) : {1'b0, m_lfsr[31:1]};
      end
    end
    if ((req_i && gnt_i) && !pop) begin
      if (m_out < DEPTH) m_out++;
    end else if (pop && !(req_i && gnt_i)) begin
      if (m_out == 0) m_perr = 1'b1;
      else m_out--;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk_i);
    cyc++;
    #1;
  endtask

  task automatic idle();
    req_i = 1'b0; gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'd0; mem_err_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    mem_rvalid_i = 1'b1; mem_rdata_i = d; mem_err_i = e;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(); rst_ni = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    vectors++;
    if ({rvalid_core_o, rdata_core_o, err_core_o, outstanding_o, gnt_block_o, overflow_o, protocol_err_o} !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b d=%h e=%b o=%0d b=%b ov=%b pe=%b, want all 0",
               rvalid_core_o, rdata_core_o, err_core_o, outstanding_o, gnt_block_o, overflow_o, protocol_err_o);
    end
  endtask

  task automatic test_zero_delay();
    for (int pass = 0; pass < 2; pass++) begin
      en_stall_i = (pass == 1); stall_mode_i = (pass == 0) ? STANDARD : 32'd7;
      rvalid_stall_i = 32'd9; max_stall_i = 32'd0;
      for (int i = 0; i < 8; i++) begin
        idle();
        if (i == 1) begin req_i = 1'b1; gnt_i = 1'b1; end
        if (i == 2) push((pass == 0) ? 32'hDEAD_BEEF : $urandom, 1'(pass));
        model_expect();
        vectors++;
        if ({rvalid_core_o, err_core_o, rdata_core_o} !== {e_rv, e_err, e_data}) begin
          miscompares++;
          $display("FAIL zero_resp cyc=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                   cyc, rvalid_core_o, err_core_o, rdata_core_o, e_rv, e_err, e_data);
        end
        vectors++;
        if ({outstanding_o, gnt_block_o, overflow_o, protocol_err_o} !== {e_out, e_blk, m_ovf, m_perr}) begin
          miscompares++;
          $display("FAIL zero_stat cyc=%0d got o=%0d b=%b ov=%b pe=%b want o=%0d b=%b ov=%b pe=%b",
                   cyc, outstanding_o, gnt_block_o, overflow_o, protocol_err_o, e_out, e_blk, m_ovf, m_perr);
        end
        if (pass == 0 && i == 3) begin
          vectors++;
          if ({rvalid_core_o, rdata_core_o} !== {1'b1, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL zero_latency got v=%b d=%h want v=1 d=deadbeef", rvalid_core_o, rdata_core_o);
          end
        end
        if (pass == 0 && i == 4) begin
          vectors++;
          if (rvalid_core_o !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_single got v=%b want 0", rvalid_core_o);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_standard();
    logic [31:0] exp_d[2];
    int          exp_i[2];
    int          hits = 0;
    exp_d[0] = $urandom; exp_d[1] = $urandom;
    exp_i[0] = 5; exp_i[1] = 9;
    en_stall_i = 1'b1; stall_mode_i = STANDARD; rvalid_stall_i = 32'd3;
    for (int i = 0; i < 15; i++) begin
      idle();
      if (i <= 1) begin req_i = 1'b1; gnt_i = 1'b1; end
      if (i == 1) push(exp_d[0], 1'b0);
      if (i == 2) push(exp_d[1], 1'b1);
      model_expect();
      vectors++;
      if ({rvalid_core_o, err_core_o, rdata_core_o} !== {e_rv, e_err, e_data}) begin
        miscompares++;
        $display("FAIL std_resp cyc=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 cyc, rvalid_core_o, err_core_o, rdata_core_o, e_rv, e_err, e_data);
      end
      vectors++;
      if ({outstanding_o, gnt_block_o, overflow_o, protocol_err_o} !== {e_out, e_blk, m_ovf, m_perr}) begin
        miscompares++;
        $display("FAIL std_stat cyc=%0d got o=%0d b=%b ov=%b pe=%b want o=%0d b=%b ov=%b pe=%b",
                 cyc, outstanding_o, gnt_block_o, overflow_o, protocol_err_o, e_out, e_blk, m_ovf, m_perr);
      end
      if (rvalid_core_o === 1'b1) begin
        if (hits < 2) begin
          vectors++;
          if (i != exp_i[hits] || rdata_core_o !== exp_d[hits]) begin
            miscompares++;
            $display("FAIL std_order resp%0d got slot=%0d d=%h want slot=%0d d=%h",
                     hits, i, rdata_core_o, exp_i[hits], exp_d[hits]);
          end
        end
        hits++;
      end
      tick();
    end
    vectors++;
    if (hits != 2) begin
      miscompares++;
      $display("FAIL std_count got %0d responses want 2", hits);
    end
  endtask

  task automatic test_random_zero();
    en_stall_i = 1'b1; stall_mode_i = RANDOM; max_stall_i = 32'd0;
    for (int i = 0; i < 9; i++) begin
      idle();
      if (i <= 3) begin req_i = 1'b1; gnt_i = 1'b1; end
      if (i >= 1 && i <= 4) push($urandom, 1'($urandom_range(1)));
      model_expect();
      vectors++;
      if ({rvalid_core_o, err_core_o, rdata_core_o} !== {e_rv, e_err, e_data}) begin
        miscompares++;
        $display("FAIL rz_resp cyc=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 cyc, rvalid_core_o, err_core_o, rdata_core_o, e_rv, e_err, e_data);
      end
      vectors++;
      if ({outstanding_o, gnt_block_o, overflow_o, protocol_err_o} !== {e_out, e_blk, m_ovf, m_perr}) begin
        miscompares++;
        $display("FAIL rz_stat cyc=%0d got o=%0d b=%b ov=%b pe=%b want o=%0d b=%b ov=%b pe=%b",
                 cyc, outstanding_o, gnt_block_o, overflow_o, protocol_err_o, e_out, e_blk, m_ovf, m_perr);
      end
      if (i >= 2 && i <= 5) begin
        vectors++;
        if (rvalid_core_o !== 1'b1) begin
          miscompares++;
          $display("FAIL rz_b2b slot=%0d got v=%b want 1", i, rvalid_core_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_full();
    logic [31:0] w[5];
    logic [31:0] got[$];
    for (int k = 0; k < 5; k++) w[k] = $urandom;
    en_stall_i = 1'b1; stall_mode_i = STANDARD; rvalid_stall_i = 32'd10;
    for (int i = 0; i < 50; i++) begin
      idle();
      if (i <= 3) begin req_i = 1'b1; gnt_i = 1'b1; end
      if (i >= 1 && i <= 5) push(w[i-1], 1'b0);
      model_expect();
      vectors++;
      if ({rvalid_core_o, err_core_o, rdata_core_o} !== {e_rv, e_err, e_data}) begin
        miscompares++;
        $display("FAIL full_resp cyc=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 cyc, rvalid_core_o, err_core_o, rdata_core_o, e_rv, e_err, e_data);
      end
      vectors++;
      if ({outstanding_o, gnt_block_o, overflow_o, protocol_err_o} !== {e_out, e_blk, m_ovf, m_perr}) begin
        miscompares++;
        $display("FAIL full_stat cyc=%0d got o=%0d b=%b ov=%b pe=%b want o=%0d b=%b ov=%b pe=%b",
                 cyc, outstanding_o, gnt_block_o, overflow_o, protocol_err_o, e_out, e_blk, m_ovf, m_perr);
      end
      if (i == 5) begin
        vectors++;
        if (gnt_block_o !== 1'b1) begin
          miscompares++;
          $display("FAIL full_block got %b want 1", gnt_block_o);
        end
      end
      if (i == 6) begin
        vectors++;
        if (overflow_o !== 1'b1) begin
          miscompares++;
          $display("FAIL full_overflow got %b want 1", overflow_o);
        end
      end
      if (rvalid_core_o === 1'b1) got.push_back(rdata_core_o);
      tick();
    end
    vectors++;
    if (got.size() != 4) begin
      miscompares++;
      $display("FAIL full_count got %0d words want 4", got.size());
    end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      vectors++;
      if (got[k] !== w[k]) begin
        miscompares++;
        $display("FAIL full_data word%0d got %h want %h", k, got[k], w[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    en_stall_i = 1'b1; stall_mode_i = STANDARD; rvalid_stall_i = 32'd20;
    for (int i = 0; i < 11; i++) begin
      idle();
      rst_ni = (i != 4);
      if (i >= 5) en_stall_i = 1'b0;
      if (i <= 1) begin req_i = 1'b1; gnt_i = 1'b1; end
      if (i == 1 || i == 2) push($urandom, 1'b0);
      if (i == 6) push(32'h1234_5678, 1'b1);
      model_expect();
      vectors++;
      if ({rvalid_core_o, err_core_o, rdata_core_o} !== {e_rv, e_err, e_data}) begin
        miscompares++;
        $display("FAIL rmid_resp cyc=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 cyc, rvalid_core_o, err_core_o, rdata_core_o, e_rv, e_err, e_data);
      end
      vectors++;
      if ({outstanding_o, gnt_block_o, overflow_o, protocol_err_o} !== {e_out, e_blk, m_ovf, m_perr}) begin
        miscompares++;
        $display("FAIL rmid_stat cyc=%0d got o=%0d b=%b ov=%b pe=%b want o=%0d b=%b ov=%b pe=%b",
                 cyc, outstanding_o, gnt_block_o, overflow_o, protocol_err_o, e_out, e_blk, m_ovf, m_perr);
      end
      if (i == 5) begin
        vectors++;
        if ({rvalid_core_o, outstanding_o, overflow_o, protocol_err_o} !== 6'd0) begin
          miscompares++;
          $display("FAIL rmid_clear got v=%b o=%0d ov=%b pe=%b want all 0",
                   rvalid_core_o, outstanding_o, overflow_o, protocol_err_o);
        end
      end
      if (i == 7) begin
        vectors++;
        if ({rvalid_core_o, err_core_o, rdata_core_o} !== {1'b1, 1'b1, 32'h1234_5678}) begin
          miscompares++;
          $display("FAIL rmid_after got v=%b e=%b d=%h want v=1 e=1 d=12345678",
                   rvalid_core_o, err_core_o, rdata_core_o);
        end
      end
      if (i == 8) begin
        vectors++;
        if (protocol_err_o !== 1'b1) begin
          miscompares++;
          $display("FAIL rmid_protocol got %b want 1", protocol_err_o);
        end
      end
      tick();
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_random();
    longint pq[$];
    longint prev_out = -1000;
    longint h, d;
    int     pushes = 0;
    int     budget = 0;
    idle(); rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    en_stall_i = 1'b1; stall_mode_i = RANDOM; max_stall_i = 32'd7;
    while ((pushes < 50 || mq.size() > 0) && budget < 3000) begin
      idle();
      req_i = 1'($urandom_range(1));
      if (pushes < 50 && mq.size() < DEPTH && $urandom_range(9) < 6) begin
        req_i = 1'b1; gnt_i = 1'b1;
        push($urandom, 1'($urandom_range(1)));
        pq.push_back(cyc);
        pushes++;
      end
      model_expect();
      vectors++;
      if ({rvalid_core_o, err_core_o, rdata_core_o} !== {e_rv, e_err, e_data}) begin
        miscompares++;
        $display("FAIL rnd_resp cyc=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 cyc, rvalid_core_o, err_core_o, rdata_core_o, e_rv, e_err, e_data);
      end
      vectors++;
      if ({outstanding_o, gnt_block_o, overflow_o, protocol_err_o} !== {e_out, e_blk, m_ovf, m_perr}) begin
        miscompares++;
        $display("FAIL rnd_stat cyc=%0d got o=%0d b=%b ov=%b pe=%b want o=%0d b=%b ov=%b pe=%b",
                 cyc, outstanding_o, gnt_block_o, overflow_o, protocol_err_o, e_out, e_blk, m_ovf, m_perr);
      end
      if (rvalid_core_o === 1'b1) begin
        vectors++;
        if (pq.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_spurious cyc=%0d response with no push pending", cyc);
        end else begin
          h = pq.pop_front();
          if (prev_out > h) h = prev_out;
          d = cyc - h - 1;
          if (d < 0 || d > 7) begin
            miscompares++;
            $display("FAIL rnd_delay cyc=%0d got delay %0d want 0..7", cyc, d);
          end
          prev_out = cyc;
        end
      end
      tick();
      budget++;
    end
    vectors++;
    if (budget >= 3000 || pq.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_timeout pushes=%0d pending=%0d want all 50 delivered", pushes, pq.size());
    end
    vectors++;
    if (protocol_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rnd_protocol got %b want 0", protocol_err_o);
    end
  endtask

  initial begin
    idle();
    rst_ni = 1'b0; en_stall_i = 1'b0; stall_mode_i = STANDARD;
    max_stall_i = 32'd0; rvalid_stall_i = 32'd0;
    #1;
    test_reset();
    test_zero_delay();
    test_standard();
    test_random_zero();
    test_full();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/obi_rvalid_delay.md
Name: obi_rvalid_delay

Overview:
- Response-phase perturbation stage. Sits directly downstream of the OBI grant stall stage in the core testbench memory path.
- Buffers read/write responses returned by the memory model and releases them to the core in order, each after a configurable stall.
- Tracks outstanding granted transactions and tells the grant stage to withhold grant when the buffer cannot absorb another response.

Parameters:
- FIFO_DEPTH, 4, number of response entries; power of two, >= 2
- DATA_WIDTH, 32, rdata width
- LFSR_SEED, 32'h1, nonzero reset value of the random-delay LFSR

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; synchronous, active-low
- req_i  input  1  core request, observed only
- gnt_i  input  1  grant as seen by the core (output of grant stall stage)
- mem_rvalid_i  input  1  response valid from memory model
- mem_rdata_i  input  DATA_WIDTH  response data from memory model
- mem_err_i  input  1  response error from memory model
- rvalid_core_o  output  1  delayed response valid to core
- rdata_core_o  output  DATA_WIDTH  delayed response data
- err_core_o  output  1  delayed response error
- en_stall_i  input  1  stall enable; 0 forces delay 0
- stall_mode_i  input  32  STANDARD or RANDOM (package constants)
- max_stall_i  input  32  RANDOM-mode upper bound, inclusive
- rvalid_stall_i  input  32  STANDARD-mode fixed delay
- outstanding_o  output  $clog2(FIFO_DEPTH+1)  granted transactions not yet answered to the core
- gnt_block_o  output  1  outstanding_o >= FIFO_DEPTH; grant stage must hold grant low
- overflow_o  output  1  sticky: response dropped because FIFO was full
- protocol_err_o  output  1  sticky: rvalid_core_o with outstanding == 0

Behaviour:
- Reset (rst_ni sampled low at a rising edge):
  - FIFO is emptied; head counter, outstanding counter and sticky flags are set to 0; LFSR is set to LFSR_SEED.
  - All outputs are 0 from the following cycle.
  - Reset mid-operation discards queued responses silently.
- Delay selection occurs at push time and is stored per entry as 32 bits:
  - en_stall_i == 0: delay = 0.
  - STANDARD: delay = rvalid_stall_i.
  - RANDOM: delay = lfsr % (max_stall_i + 1). If max_stall_i == 32'hFFFFFFFF, delay = lfsr.
  - Any other mode: delay = 0.
- LFSR: 32-bit Galois, polynomial 0x80200003. It advances exactly once per accepted push, in any mode.
- Push: mem_rvalid_i == 1 stores {rdata, err, delay}.
- Head countdown:
  - head_cnt is loaded with the entry's delay in the cycle that entry becomes head.
  - An entry becomes head when it is pushed into an empty FIFO, or when it is pushed while the last entry pops in the same cycle.
  - On a pop that leaves entries behind, the next entry's delay is loaded.
  - Otherwise head_cnt decrements while nonzero.
- Output: rvalid_core_o = !empty && head_cnt == 0, decoded directly from flops.
  - rdata_core_o and err_core_o show the head entry when rvalid_core_o == 1; they are 0 otherwise.
  - Pop occurs in every cycle where rvalid_core_o == 1; the core cannot backpressure.
- Latency: a response pushed in cycle N into an empty FIFO gives rvalid_core_o in cycle N+1+d. A queued entry gives rvalid in cycle P+1+d, where P is the cycle its predecessor popped.
- Throughput: one response per cycle at d = 0. Order is always preserved.
- Full:
  - Push while full with no pop: entry dropped, overflow_o set, LFSR not advanced.
  - Push while full with a simultaneous pop: push accepted.
- Outstanding counter:
  - +1 on req_i && gnt_i; -1 on rvalid_core_o; unchanged when both occur in the same cycle.
  - Saturates at FIFO_DEPTH.
  - Decrement at 0: counter stays 0 and protocol_err_o is set.

Decomposition:
- Package perturbation_defines:
  - STANDARD = 0, RANDOM = 1 mode constants.
  - LFSR polynomial constant.
  - Typedef rvalid_entry_t {data, err, delay[31:0]}.
- One sub-module, obi_delay_lfsr: seedable Galois LFSR with an advance strobe. Used here and reusable by the grant stage for synthesizable randomness.

Test Plan:
1. en_stall_i = 0; mem_rvalid_i in cycle 10 with rdata 0xDEADBEEF, err 0 -> rvalid_core_o = 1 only in cycle 11, rdata_core_o = 0xDEADBEEF.
2. STANDARD, rvalid_stall_i = 3; pushes A in cycle 10 and B in cycle 11 -> A out in cycle 14, B out in cycle 18, order A then B.
3. RANDOM, max_stall_i = 0; pushes in cycles 20..23 -> rvalid_core_o high in cycles 21..24 back-to-back; LFSR advanced 4 times.
4. FIFO_DEPTH = 4, STANDARD delay 10; 4 grants -> gnt_block_o = 1 after the 4th. A 5th push with the FIFO full -> overflow_o = 1, the 4 original data words are delivered unchanged.
5. Two entries queued, then rst_ni low for one edge -> next cycle rvalid_core_o = 0, outstanding_o = 0, flags 0. A subsequent push with d = 0 returns one cycle later.
6. RANDOM, max_stall_i = 7, LFSR_SEED = 1, 50 pushes -> every delay <= 7 and matching a scoreboard LFSR model; order preserved; protocol_err_o stays 0.
